// File: rtl/cgol_pkg.sv
// Shared types and default board geometry for the Game-of-Life seed loader,
// generation engine and board state store.
package cgol_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_REGBITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    RUN   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/gen_ticker.sv
// Generation pacer: divides clk by TICKDIV into one-cycle gen_tick pulses and
// counts generations. clear zeroes both counters; dropping enable discards a pending tick.
module gen_ticker #(
  parameter int TICKDIV = 1000000,
  parameter int CNTBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  output logic               gen_tick,
  output logic [CNTBITS-1:0] gen_count
);

  localparam int TW = $clog2(TICKDIV);
  localparam logic [TW-1:0] TMAX = TW'(TICKDIV - 1);

  logic [TW-1:0]      cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [CNTBITS-1:0] count_q, count_d;

  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    count_d = count_q;
    if (clear) begin
      cnt_d   = '0;
      count_d = '0;
    end else if (enable) begin
      if (cnt_q == TMAX) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        count_d = count_q + CNTBITS'(1);
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      count_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      count_q <= count_d;
    end
  end

  assign gen_tick  = tick_q;
  assign gen_count = count_q;

endmodule

// File: rtl/seed_loader.sv
// Seed loader: streams one board row per handshake into the state store, then
// releases and paces the generation engine. Optional checksum word: SEED_CHECKSUM_EN.
module seed_loader
  import cgol_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int REGBITS = DEF_REGBITS,
  parameter int TICKDIV = 1000000,
  parameter int CNTBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [REGBITS-1:0] wr_addr,
  output logic [WIDTH-1:0]   wr_data,
  output logic               run,
  output logic               gen_tick,
  output logic [CNTBITS-1:0] gen_count,
  output logic               load_done,
  output logic               seed_err,
  output loader_state_t      dbg_state
);

  localparam logic [REGBITS-1:0] LAST_ROW = '1;

  loader_state_t      state_q, state_d;
  logic [REGBITS-1:0] idx_q, idx_d;
  logic               in_ready_q;
  logic               wr_en_q, wr_en_d;
  logic [REGBITS-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic               run_q, load_done_q;
  logic               accept, enter_run, tick_enable;
`ifdef SEED_CHECKSUM_EN
  logic [WIDTH-1:0]   csum_q, csum_d;
  logic               err_q, err_d;
`endif

  // A word transfers on a rising edge with in_valid=1 and in_ready=1, unless
  // load_req is high that cycle: the restart wins and the word is dropped.
  assign accept = in_valid & in_ready_q & ~load_req;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef SEED_CHECKSUM_EN
    csum_d    = csum_q;
    err_d     = err_q;
`endif
    if (load_req) begin
      state_d = LOAD;
      idx_d   = '0;
`ifdef SEED_CHECKSUM_EN
      csum_d  = '0;
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = in_data;
            idx_d     = idx_q + REGBITS'(1);
`ifdef SEED_CHECKSUM_EN
            csum_d    = csum_q ^ in_data;
            if (idx_q == LAST_ROW) state_d = CHECK;
`else
            if (idx_q == LAST_ROW) state_d = RUN;
`endif
          end
        end
`ifdef SEED_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (in_data == csum_q) begin
              state_d = RUN;
              err_d   = 1'b0;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign enter_run   = (state_d == RUN) && (state_q != RUN);
  // Ticking only while staying in RUN drops a tick that would land on the exit cycle.
  assign tick_enable = (state_q == RUN) && (state_d == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      run_q       <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= (state_d == LOAD) || (state_d == CHECK);
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      run_q       <= (state_d == RUN);
      load_done_q <= enter_run;
    end
  end

`ifdef SEED_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end

  assign seed_err = err_q;
`else
  assign seed_err = 1'b0;
`endif

  gen_ticker #(
    .TICKDIV (TICKDIV),
    .CNTBITS (CNTBITS)
  ) u_ticker (
    .clk       (clk),
    .reset     (reset),
    .clear     (enter_run),
    .enable    (tick_enable),
    .gen_tick  (gen_tick),
    .gen_count (gen_count)
  );

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign run       = run_q;
  assign load_done = load_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seed_loader.sv
// Bench for seed_loader with TICKDIV=4: row writes go through an expected-write
// scoreboard; control outputs are checked directly against hand-derived values.
module tb_seed_loader;
  import cgol_pkg::*;

  localparam int W  = 8;
  localparam int RB = 3;
  localparam int TD = 4;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          reset, load_req, in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready, wr_en, run, gen_tick, load_done, seed_err;
  logic [RB-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [CB-1:0] gen_count;
  loader_state_t dbg_state;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;
  logic [RB+W-1:0] exp_q[$];

  seed_loader #(
    .WIDTH   (W),
    .REGBITS (RB),
    .TICKDIV (TD),
    .CNTBITS (CB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_req  (load_req),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .run       (run),
    .gen_tick  (gen_tick),
    .gen_count (gen_count),
    .load_done (load_done),
    .seed_err  (seed_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    cycle();
    load_req = 1'b0;
  endtask

  // Presents one word for one cycle; caller knows in_ready is high, so it is accepted.
  task automatic send_row(input logic [W-1:0] d, input logic [RB-1:0] a);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back({a, d});
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic send_unwritten(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        logic [RB+W-1:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL wr_row: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                   wr_addr, wr_data, e[RB+W-1:W], e[W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] glider [8];
  int ticks;

  initial begin
    glider[0] = 8'h40; glider[1] = 8'h20; glider[2] = 8'hE0;
    for (int i = 3; i < 8; i++) glider[i] = 8'h00;
    reset = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) cycle();
    mon_en = 1'b1;
    check("rst_state", dbg_state, IDLE);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_run", run, 0);
    check("rst_gen_tick", gen_tick, 0);
    check("rst_gen_count", gen_count, 0);
    check("rst_load_done", load_done, 0);
    check("rst_seed_err", seed_err, 0);
    reset = 1'b0;
    cycle();
    check("idle_hold", dbg_state, IDLE);

    // Glider load, back-to-back words
    pulse_load_req();
    check("load_state", dbg_state, LOAD);
    check("load_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      check("load_no_done", load_done, 0);
      send_row(glider[i], RB'(i));
    end
    check("glider_load_done", load_done, 1);
    check("glider_run", run, 1);
    check("glider_gen_count0", gen_count, 0);
    check("glider_in_ready", in_ready, 0);
    check("glider_state", dbg_state, RUN);

    // Tick pacing: ticks land on cycles 4,8,12,16,20 after RUN entry
    ticks = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      check("tick_pattern", gen_tick, (k % TD == 0) ? 1 : 0);
      if (k == 1) check("done_single_pulse", load_done, 0);
      if (gen_tick === 1'b1) ticks++;
    end
    check("tick_count", ticks, 5);
    check("gen_count_5", gen_count, 5);

    // Reload from RUN just before a tick is due: that tick is discarded
    repeat (3) begin
      cycle();
      check("tick_gap", gen_tick, 0);
    end
    load_req = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    cycle();
    load_req = 1'b0;
    in_valid = 1'b0;
    check("reload_run_drop", run, 0);
    check("reload_tick_discard", gen_tick, 0);
    check("reload_state", dbg_state, LOAD);
    check("reload_no_write", wr_en, 0);

    // in_valid 1,0,1 with load_req on the third word
    send_row(8'h11, 3'd0);
    check("gap_tick", gen_tick, 0);
    cycle();
    load_req = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h22;
    cycle();
    load_req = 1'b0;
    in_valid = 1'b0;
    check("restart_no_write", wr_en, 0);
    check("restart_state", dbg_state, LOAD);
    for (int i = 0; i < 8; i++) begin
      check("reload_no_tick", gen_tick, 0);
      check("reload_run_low", run, 0);
      send_row(W'(8'h81 + i), RB'(i));
    end
    check("reload_done", load_done, 1);
    check("reload_gen_count0", gen_count, 0);
    check("reload_run", run, 1);

    // Reset in the middle of a load: no further writes, back to IDLE
    pulse_load_req();
    send_row(8'h5A, 3'd0);
    send_row(8'hA5, 3'd1);
    send_row(8'h3C, 3'd2);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    reset    = 1'b1;
    cycle();
    check("midrst_wr_en", wr_en, 0);
    check("midrst_state", dbg_state, IDLE);
    reset    = 1'b0;
    cycle();
    in_valid = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_wr_en2", wr_en, 0);
    check("midrst_run", run, 0);

`ifdef SEED_CHECKSUM_EN
    // Rows 0x01..0x08 XOR to 0x08
    pulse_load_req();
    for (int i = 0; i < 8; i++) send_row(W'(i + 1), RB'(i));
    check("cs_check_state", dbg_state, CHECK);
    check("cs_check_ready", in_ready, 1);
    check("cs_no_done_yet", load_done, 0);
    send_unwritten(8'h08);
    check("cs_ok_state", dbg_state, RUN);
    check("cs_ok_done", load_done, 1);
    check("cs_ok_err", seed_err, 0);
    check("cs_ok_no_write", wr_en, 0);

    pulse_load_req();
    for (int i = 0; i < 8; i++) send_row(W'(i + 1), RB'(i));
    send_unwritten(8'h09);
    check("cs_bad_state", dbg_state, IDLE);
    check("cs_bad_err", seed_err, 1);
    check("cs_bad_run", run, 0);
    check("cs_bad_no_done", load_done, 0);
    check("cs_bad_no_write", wr_en, 0);
    cycle();
    check("cs_err_sticky", seed_err, 1);
    pulse_load_req();
    check("cs_err_cleared", seed_err, 0);
`endif

    repeat (2) cycle();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
